xy_scan_mux: RTL

Time-multiplexes the coordinate streams of the left plate, right plate and ball generators onto the single 8-bit X/Y DAC pair driving the oscilloscope in X-Y mode. Each source gets a fixed slot: a blanked settle window while the beam slews, then a dwell window in which that source's live coordinates pass through to the DAC. The block sits between the sprite generators and the DAC output pins and also provides a frame marker to the game logic.

---
 rtl/xy_scan_mux.sv | 128 ++++++++++++
 1 files changed

// File: rtl/xy_scan_mux.sv
// Time-multiplexes left plate, right plate and ball coordinates onto one X/Y DAC pair.
// Optional beam-blank settle window per slot enabled by defining XY_SCAN_BLANK_EN.
module xy_scan_mux #(
  parameter int SETTLE_CYCLES = 4,
  parameter int PLATE_DWELL   = 64,
  parameter int BALL_DWELL    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] x_pl,
  input  logic [7:0] y_pl,
  input  logic [7:0] x_pr,
  input  logic [7:0] y_pr,
  input  logic [7:0] x_b,
  input  logic [7:0] y_b,
  input  logic       ball_visible,
  output logic [7:0] x_out,
  output logic [7:0] y_out,
  output logic       blank,
  output logic [1:0] src,
  output logic       frame_start
);

  typedef enum logic {SETTLE, DRAW} state_t;

  // A dwell of 0 behaves like a dwell of 1, so its reload value is also 0.
  localparam logic [7:0] PLATE_LOAD = (PLATE_DWELL == 0) ? 8'd0 : 8'(PLATE_DWELL - 1);
  localparam logic [7:0] BALL_LOAD  = (BALL_DWELL == 0) ? 8'd0 : 8'(BALL_DWELL - 1);

`ifdef XY_SCAN_BLANK_EN
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam state_t     FIRST_STATE = SETTLE;
  localparam logic [7:0] FIRST_LOAD  = SETTLE_LOAD;
`else
  localparam state_t     FIRST_STATE = DRAW;
  localparam logic [7:0] FIRST_LOAD  = PLATE_LOAD;
`endif

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] src_q, src_d;
  logic [7:0] x_q, x_d;
  logic [7:0] y_q, y_d;
  logic [1:0] next_src;

  function automatic logic [7:0] dwell_for(input logic [1:0] s);
    return (s == 2'd2) ? BALL_LOAD : PLATE_LOAD;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FIRST_STATE;
      cnt_q   <= FIRST_LOAD;
      src_q   <= 2'd0;
      x_q     <= 8'h00;
      y_q     <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  always_comb begin
    next_src = 2'd0;
    x_d      = 8'h00;
    y_d      = 8'h00;
    state_d  = state_q;
    cnt_d    = cnt_q - 8'd1;
    src_d    = src_q;

    // ball_visible only matters at the moment the right-plate slot ends.
    case (src_q)
      2'd0:    next_src = 2'd1;
      2'd1:    next_src = ball_visible ? 2'd2 : 2'd0;
      default: next_src = 2'd0;
    endcase

    case (src_q)
      2'd0: begin x_d = x_pl; y_d = y_pl; end
      2'd1: begin x_d = x_pr; y_d = y_pr; end
      2'd2: begin x_d = x_b;  y_d = y_b;  end
      default: begin x_d = 8'h00; y_d = 8'h00; end
    endcase

`ifdef XY_SCAN_BLANK_EN
    if (src_q == 2'd3) begin
      state_d = SETTLE;
      src_d   = 2'd0;
      cnt_d   = SETTLE_LOAD;
    end else if (state_q == SETTLE) begin
      if (cnt_q == 8'd0) begin
        state_d = DRAW;
        cnt_d   = dwell_for(src_q);
      end
    end else if (cnt_q == 8'd0) begin
      state_d = SETTLE;
      src_d   = next_src;
      cnt_d   = SETTLE_LOAD;
    end
`else
    state_d = DRAW;
    if (src_q == 2'd3) begin
      src_d = 2'd0;
      cnt_d = PLATE_LOAD;
    end else if (cnt_q == 8'd0) begin
      src_d = next_src;
      cnt_d = dwell_for(next_src);
    end
`endif
  end

  assign x_out = x_q;
  assign y_out = y_q;
  assign src   = src_q;

`ifdef XY_SCAN_BLANK_EN
  assign blank = (state_q == SETTLE);
`else
  assign blank = 1'b0;
`endif

  // Decoded rather than registered so it is already high on the first cycle after reset release.
  assign frame_start = !rst && (state_q == FIRST_STATE) && (src_q == 2'd0) && (cnt_q == FIRST_LOAD);

endmodule
